// File: rtl/clock_div_gen.sv
// clock_div_gen: multi-channel programmable clock divider / clock-enable generator.
// Each channel counts 0..D-1 and drives a registered divided clock (high for
// ceil(D/2) cycles) plus a one-cycle enable that coincides with its rising edge.
// Divisor writes are staged per channel and applied at the next period wrap.
// Optional macro PHASE_ALIGN_EN adds sync_in, which restarts all enabled
// channels on the same edge.

module clock_div_ch #(
  parameter int DIV_W     = 16,
  parameter int DIV_RESET = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  output logic             pend,
  output logic             clk_o,
  output logic             ce_o
);

  logic [DIV_W-1:0] cnt, d, pdiv;
  logic [DIV_W-1:0] d_eff, cnt_nxt;
  logic [DIV_W:0]   half;
  logic             wrap, restart, apply;

  // Next count and the divisor the coming edge must honour; a pending divisor
  // is folded in on the restart edge so the first new period is never a runt.
  always_comb begin
    wrap    = (cnt == d - DIV_W'(1));
    restart = wrap || sync;
    apply   = pend && restart;
    d_eff   = apply ? pdiv : d;
    cnt_nxt = restart ? '0 : cnt + DIV_W'(1);
    half    = ({1'b0, d_eff} + (DIV_W+1)'(1)) >> 1;
  end

  // Counter, active/pending divisor and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      d     <= DIV_W'(DIV_RESET);
      pdiv  <= DIV_W'(DIV_RESET);
      pend  <= 1'b0;
      clk_o <= 1'b0;
      ce_o  <= 1'b0;
    end else begin
      if (!en) begin
        cnt   <= '0;
        clk_o <= 1'b0;
        ce_o  <= 1'b0;
        // Idle channel has no period to protect: take the new divisor now.
        if (pend) begin
          d    <= pdiv;
          pend <= 1'b0;
        end
      end else begin
        cnt   <= cnt_nxt;
        clk_o <= ({1'b0, cnt_nxt} < half);
        ce_o  <= (cnt_nxt == '0);
        if (apply) begin
          d    <= pdiv;
          pend <= 1'b0;
        end
      end
      // Writes only arrive while pend is low, so they never race an apply.
      if (wr) begin
        pdiv <= wr_div;
        pend <= 1'b1;
      end
    end
  end

endmodule

module clock_div_gen #(
  parameter int NUM_CH    = 2,
  parameter int DIV_W     = 16,
  parameter int DIV_RESET = 2,
  parameter int CH_W      = 3
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic [NUM_CH-1:0] enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
`ifdef PHASE_ALIGN_EN
  input  logic              sync_in,
`endif
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] ce_out
);

  logic [NUM_CH-1:0]    pend, wr;
  logic [2**CH_W-1:0]   pend_ext;
  logic [DIV_W-1:0]     div_c;
  logic                 sync;

`ifdef PHASE_ALIGN_EN
  assign sync = sync_in;
`else
  assign sync = 1'b0;
`endif

  // Divisors below 2 cannot form a period; store them as 2.
  assign div_c = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;

  // Ready per addressed channel; unimplemented channel numbers always accept
  // (and drop) the write because their pending bit reads as 0.
  always_comb begin
    pend_ext = '0;
    for (int i = 0; i < NUM_CH; i++) pend_ext[i] = pend[i];
    cfg_ready = !pend_ext[cfg_ch];
  end

  // Decode an accepted write to its channel.
  always_comb begin
    wr = '0;
    for (int i = 0; i < NUM_CH; i++)
      wr[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clock_div_ch #(
      .DIV_W    (DIV_W),
      .DIV_RESET(DIV_RESET)
    ) u_ch (
      .clk   (CLOCK_50),
      .rst_n (RESET_N),
      .en    (enable[g]),
      .sync  (sync),
      .wr    (wr[g]),
      .wr_div(div_c),
      .pend  (pend[g]),
      .clk_o (clk_out[g]),
      .ce_o  (ce_out[g])
    );
  end

endmodule

// File: tb/tb_clock_div_gen.sv
// Directed bench for clock_div_gen (NUM_CH=2). Stimulus pushes hand-computed
// expected outputs into a queue; a monitor pops one entry per clock edge.
module tb_clock_div_gen;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N  = 1'b0;
  logic [1:0]  enable   = '0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [2:0]  cfg_ch   = '0;
  logic [15:0] cfg_div  = '0;
  logic        sync_r   = 1'b0;
  logic [1:0]  clk_out, ce_out;

  typedef struct packed {
    logic [1:0]  clk;
    logic [1:0]  ce;
    logic        rdy;
    logic [1:0]  m;
    logic [15:0] id;
  } exp_t;

  exp_t        q[$];
  int          nvec = 0;
  int          nmis = 0;
  logic [15:0] vec_id = '0;
  logic        rdy_s;

  clock_div_gen #(.NUM_CH(2), .DIV_W(16), .DIV_RESET(2), .CH_W(3)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .enable   (enable),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
`ifdef PHASE_ALIGN_EN
    .sync_in  (sync_r),
`endif
    .clk_out  (clk_out),
    .ce_out   (ce_out)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Drive one cycle of inputs and queue what the following edge must produce.
  task automatic step(input logic [1:0] en, input logic v, input logic [2:0] ch,
                      input logic [15:0] dv, input logic sy, input logic [1:0] ec,
                      input logic [1:0] ee, input logic er, input logic [1:0] m);
    exp_t e;
    @(negedge CLOCK_50);
    enable = en; cfg_valid = v; cfg_ch = ch; cfg_div = dv; sync_r = sy;
    vec_id = vec_id + 16'd1;
    e.clk = ec; e.ce = ee; e.rdy = er; e.m = m; e.id = vec_id;
    q.push_back(e);
  endtask

  task automatic check_now(input string name, input logic [3:0] act, input logic [3:0] req);
    nvec++;
    if (act !== req) begin
      nmis++;
      $display("FAIL %s got clk/ce=%b required %b", name, act, req);
    end
  endtask

  // Monitor: ready sampled mid-cycle, registered outputs just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLOCK_50);
      #3 rdy_s = cfg_ready;
      @(posedge CLOCK_50);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        nvec++;
        if ((((clk_out ^ e.clk) & e.m) != 2'b00) || (((ce_out ^ e.ce) & e.m) != 2'b00) ||
            (rdy_s !== e.rdy)) begin
          nmis++;
          $display("FAIL vec%0d got clk=%b ce=%b rdy=%b required clk=%b ce=%b rdy=%b mask=%b",
                   e.id, clk_out, ce_out, rdy_s, e.clk, e.ce, e.rdy, e.m);
        end
      end
    end
  end

`ifdef PHASE_ALIGN_EN
  logic [11:0] pa_clk0 = 12'b101101101101;
  logic [11:0] pa_clk1 = 12'b100110011001;
  logic [11:0] pa_ce0  = 12'b001001001001;
  logic [11:0] pa_ce1  = 12'b000100010001;
`endif

  initial begin
    repeat (3) @(negedge CLOCK_50);
    check_now("in_reset", {clk_out, ce_out}, 4'b0000);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;

    // Default D=2 on ch0, ch1 idle.
    step(2'b00, 0, 3'd0, 16'd0, 0, 2'b00, 2'b00, 1, 2'b11);
    step(2'b01, 0, 3'd0, 16'd0, 0, 2'b00, 2'b00, 1, 2'b11);
    step(2'b01, 0, 3'd0, 16'd0, 0, 2'b01, 2'b01, 1, 2'b11);
    step(2'b01, 0, 3'd0, 16'd0, 0, 2'b00, 2'b00, 1, 2'b11);
    step(2'b01, 0, 3'd0, 16'd0, 0, 2'b01, 2'b01, 1, 2'b11);
    step(2'b01, 0, 3'd0, 16'd0, 0, 2'b00, 2'b00, 1, 2'b11);
    step(2'b01, 0, 3'd0, 16'd0, 0, 2'b01, 2'b01, 1, 2'b11);
    // ch1 divisor 5 while idle, then run: high 3, low 2.
    step(2'b01, 1, 3'd1, 16'd5, 0, 2'b00, 2'b00, 1, 2'b11);
    step(2'b01, 0, 3'd1, 16'd0, 0, 2'b01, 2'b01, 0, 2'b11);
    step(2'b11, 0, 3'd1, 16'd0, 0, 2'b10, 2'b00, 1, 2'b11);
    step(2'b11, 0, 3'd1, 16'd0, 0, 2'b11, 2'b01, 1, 2'b11);
    step(2'b11, 0, 3'd1, 16'd0, 0, 2'b00, 2'b00, 1, 2'b11);
    step(2'b11, 0, 3'd1, 16'd0, 0, 2'b01, 2'b01, 1, 2'b11);
    step(2'b11, 0, 3'd1, 16'd0, 0, 2'b10, 2'b10, 1, 2'b11);
    step(2'b11, 0, 3'd1, 16'd0, 0, 2'b11, 2'b01, 1, 2'b11);
    step(2'b11, 0, 3'd1, 16'd0, 0, 2'b10, 2'b00, 1, 2'b11);
    step(2'b11, 0, 3'd1, 16'd0, 0, 2'b01, 2'b01, 1, 2'b11);
    step(2'b11, 0, 3'd1, 16'd0, 0, 2'b00, 2'b00, 1, 2'b11);
    step(2'b11, 0, 3'd1, 16'd0, 0, 2'b11, 2'b11, 1, 2'b11);
    // ch0 -> 4 mid-period, held off until wrap, then -> 3 on the next cycle.
    step(2'b11, 1, 3'd0, 16'd4, 0, 2'b10, 2'b00, 1, 2'b11);
    step(2'b11, 1, 3'd0, 16'd3, 0, 2'b11, 2'b01, 0, 2'b11);
    step(2'b11, 1, 3'd0, 16'd3, 0, 2'b01, 2'b00, 1, 2'b11);
    step(2'b11, 0, 3'd0, 16'd0, 0, 2'b00, 2'b00, 0, 2'b11);
    step(2'b11, 0, 3'd0, 16'd0, 0, 2'b10, 2'b10, 0, 2'b11);
    step(2'b11, 0, 3'd0, 16'd0, 0, 2'b11, 2'b01, 0, 2'b11);
    step(2'b11, 0, 3'd0, 16'd0, 0, 2'b11, 2'b00, 1, 2'b11);
    step(2'b11, 0, 3'd0, 16'd0, 0, 2'b00, 2'b00, 1, 2'b11);
    step(2'b11, 0, 3'd0, 16'd0, 0, 2'b01, 2'b01, 1, 2'b11);
    // div=0 to ch1, write to absent ch7, then ch1 runs as D=2.
    step(2'b01, 1, 3'd1, 16'd0, 0, 2'b01, 2'b00, 1, 2'b11);
    step(2'b01, 1, 3'd7, 16'd9, 0, 2'b00, 2'b00, 1, 2'b11);
    step(2'b11, 0, 3'd0, 16'd0, 0, 2'b01, 2'b01, 1, 2'b11);
    step(2'b11, 0, 3'd0, 16'd0, 0, 2'b11, 2'b10, 1, 2'b11);
    step(2'b11, 0, 3'd0, 16'd0, 0, 2'b00, 2'b00, 1, 2'b11);
    step(2'b11, 0, 3'd0, 16'd0, 0, 2'b11, 2'b11, 1, 2'b11);
    // div=1 to ch1.
    step(2'b01, 1, 3'd1, 16'd1, 0, 2'b01, 2'b00, 1, 2'b11);
    step(2'b01, 0, 3'd1, 16'd0, 0, 2'b00, 2'b00, 0, 2'b11);
    step(2'b11, 0, 3'd1, 16'd0, 0, 2'b01, 2'b01, 1, 2'b11);
    step(2'b11, 0, 3'd1, 16'd0, 0, 2'b11, 2'b10, 1, 2'b11);
    step(2'b11, 0, 3'd1, 16'd0, 0, 2'b00, 2'b00, 1, 2'b11);
    step(2'b11, 0, 3'd1, 16'd0, 0, 2'b11, 2'b11, 1, 2'b11);
    // Disable mid-period, restart ch0 from zero.
    step(2'b11, 0, 3'd0, 16'd0, 0, 2'b01, 2'b00, 1, 2'b11);
    step(2'b00, 0, 3'd0, 16'd0, 0, 2'b00, 2'b00, 1, 2'b11);
    step(2'b01, 0, 3'd0, 16'd0, 0, 2'b01, 2'b00, 1, 2'b11);
    step(2'b01, 0, 3'd0, 16'd0, 0, 2'b00, 2'b00, 1, 2'b11);
    step(2'b01, 1, 3'd0, 16'd7, 0, 2'b01, 2'b01, 1, 2'b11);

    // Async reset between edges while ch0 is high; pending 7 must be lost.
    @(posedge CLOCK_50);
    #4 RESET_N = 1'b0;
    #1 check_now("async_reset", {clk_out, ce_out}, 4'b0000);
    enable = 2'b00; cfg_valid = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    RESET_N = 1'b1;
    step(2'b01, 0, 3'd0, 16'd0, 0, 2'b00, 2'b00, 1, 2'b11);
    step(2'b01, 0, 3'd0, 16'd0, 0, 2'b01, 2'b01, 1, 2'b11);
    step(2'b01, 0, 3'd0, 16'd0, 0, 2'b00, 2'b00, 1, 2'b11);
    step(2'b01, 0, 3'd0, 16'd0, 0, 2'b01, 2'b01, 1, 2'b11);

`ifdef PHASE_ALIGN_EN
    // ch0 D=3, ch1 D=4, free run, then sync: common rise, realign after 12.
    step(2'b00, 1, 3'd0, 16'd3, 0, 2'b00, 2'b00, 1, 2'b11);
    step(2'b00, 1, 3'd1, 16'd4, 0, 2'b00, 2'b00, 1, 2'b11);
    step(2'b00, 0, 3'd1, 16'd0, 0, 2'b00, 2'b00, 0, 2'b11);
    repeat (5) step(2'b11, 0, 3'd0, 16'd0, 0, 2'b00, 2'b00, 1, 2'b00);
    step(2'b11, 0, 3'd0, 16'd0, 1, 2'b11, 2'b11, 1, 2'b11);
    for (int k = 1; k <= 12; k++)
      step(2'b11, 0, 3'd0, 16'd0, 0, {pa_clk1[12-k], pa_clk0[12-k]},
           {pa_ce1[12-k], pa_ce0[12-k]}, 1, 2'b11);
`endif

    for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge CLOCK_50);
    if (q.size() > 0) begin
      nvec++;
      nmis++;
      $display("FAIL drain got %0d entries left required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
